// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the feature-map writeback state type.
package cnn_pkg;
  localparam int          CNN_DATA_W  = 16;
  localparam logic [15:0] ACT_SAT_MAX = 16'd6144;

  typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DRAIN, WB_DONE} wb_state_t;
endpackage

// File: rtl/fmap_writeback_if.sv
// Activation-sample input and memory write port of the feature-map writeback.
interface fmap_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              stall;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_ready;

  modport master (output in_data, in_valid, mem_ready,
                  input  stall, mem_wr_en, mem_addr, mem_wr_data);
  modport slave  (input  in_data, in_valid, mem_ready,
                  output stall, mem_wr_en, mem_addr, mem_wr_data);
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered occupancy count and synchronous flush.
module wb_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fmap_writeback.sv
// Buffers flagged activation samples and writes one feature map linearly to memory.
// Optional FMAP_WB_RANGE_CHECK_EN flags accepted samples outside [0, SAT_MAX].
module fmap_writeback import cnn_pkg::*; #(
  parameter int DATA_W     = CNN_DATA_W,
  parameter int FMAP_W     = 28,
  parameter int FMAP_H     = 28,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 10,
  parameter int SAT_MAX    = ACT_SAT_MAX
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  fmap_writeback_if.slave     bus,
  output logic                done,
  output logic                overflow,
  output logic                range_err
);
  localparam int TOTAL = FMAP_W * FMAP_H;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]  TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0]  LAST_C  = CW'(TOTAL - 1);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);
  localparam logic [FCW-1:0] STALL_C = FCW'(FIFO_DEPTH - 2);

  wb_state_t         state, nstate;
  logic [CW-1:0]     push_cnt, wr_cnt;
  logic [ADDR_W-1:0] base_q;
  logic              flush, push_try, push, pop, full, empty;
  logic [FCW-1:0]    count;
  logic [DATA_W-1:0] head;

  assign flush    = !start;
  assign push_try = bus.in_valid && start && (state == WB_RUN) && (push_cnt < TOTAL_C);
  assign push     = push_try && !full;

  assign bus.mem_wr_en   = !empty && (state == WB_RUN || state == WB_DRAIN);
  assign pop             = bus.mem_wr_en && bus.mem_ready;
  assign bus.mem_addr    = base_q + ADDR_W'(wr_cnt);
  // Gate the head so an empty FIFO never exposes stale storage on the bus.
  assign bus.mem_wr_data = empty ? '0 : head;
  assign bus.stall       = (count >= STALL_C);
  assign done            = (state == WB_DONE);

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .din     (bus.in_data),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    nstate = state;
    if (!start) nstate = WB_IDLE;
    else begin
      case (state)
        WB_IDLE:  nstate = WB_RUN;
        WB_RUN:   if (push && push_cnt == LAST_C) nstate = WB_DRAIN;
        WB_DRAIN: if (pop && wr_cnt == LAST_C)    nstate = WB_DONE;
        default:  nstate = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= WB_IDLE;
      push_cnt <= '0;
      wr_cnt   <= '0;
      base_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      if (!start) begin
        push_cnt <= '0;
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end else if (state == WB_IDLE) begin
        base_q   <= base_addr;
        push_cnt <= '0;
        wr_cnt   <= '0;
      end else begin
        if (push) push_cnt <= push_cnt + ONE_C;
        if (pop)  wr_cnt   <= wr_cnt + ONE_C;
        // Full blocks the push even when the head is popping this cycle.
        if (push_try && full) overflow <= 1'b1;
      end
    end
  end

`ifdef FMAP_WB_RANGE_CHECK_EN
  localparam logic signed [DATA_W-1:0] SAT_C = DATA_W'(SAT_MAX);
  logic signed [DATA_W-1:0] sdata;
  assign sdata = $signed(bus.in_data);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                                      range_err <= 1'b0;
    else if (!start)                                   range_err <= 1'b0;
    else if (push && (sdata[DATA_W-1] || sdata > SAT_C)) range_err <= 1'b1;
  end
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_fmap_writeback.sv
// Randomized bench for fmap_writeback on a 4x4 map against a queue-based reference model.
module tb_fmap_writeback;
  localparam int DW = 16, AW = 10, DEPTH = 8, TOTAL = 16;

  logic          clk = 1'b0, n_reset = 1'b1, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          done, overflow, range_err;
  int            n_chk = 0, n_pass = 0;

  fmap_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  fmap_writeback #(.DATA_W(DW), .FMAP_W(4), .FMAP_H(4), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .base_addr(base_addr),
    .bus(bus.slave), .done(done), .overflow(overflow), .range_err(range_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a map is either inactive or in progress; queue holds buffered samples.
  bit            m_on = 0, m_ovf = 0, m_rng = 0;
  logic [DW-1:0] q[$];
  int            pushed = 0, written = 0;
  logic [AW-1:0] m_base = '0;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_on = 0; q.delete(); pushed = 0; written = 0; m_base = '0; m_ovf = 0; m_rng = 0;
    end else if (!start) begin
      m_on = 0; q.delete(); pushed = 0; written = 0; m_ovf = 0; m_rng = 0;
    end else if (!m_on) begin
      m_on = 1; m_base = base_addr; pushed = 0; written = 0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() > 0) && bus.mem_ready;
      do_push = bus.in_valid && pushed < TOTAL && q.size() < DEPTH;
      if (bus.in_valid && pushed < TOTAL && q.size() >= DEPTH) m_ovf = 1;
      if (do_pop) begin void'(q.pop_front()); written++; end
      if (do_push) begin
        q.push_back(bus.in_data);
        pushed++;
`ifdef FMAP_WB_RANGE_CHECK_EN
        if (int'($signed(bus.in_data)) < 0 || int'($signed(bus.in_data)) > 6144) m_rng = 1;
`endif
      end
    end
  end

  // Commit log, captured when the handshake is set up ahead of the next edge.
  logic [AW+DW-1:0] log_q[$];

  always @(negedge clk) begin
    logic [AW-1:0] ea;
    ea = m_base + AW'(written);
    chk("stall",     bus.stall,       32'(q.size() >= DEPTH - 2));
    chk("mem_wr_en", bus.mem_wr_en,   32'(m_on && q.size() > 0));
    chk("mem_addr",  bus.mem_addr,    32'(ea));
    chk("mem_data",  bus.mem_wr_data, 32'(q.size() > 0 ? q[0] : 16'h0));
    chk("done",      done,            32'(m_on && written == TOTAL));
    chk("overflow",  overflow,        32'(m_ovf));
    chk("range_err", range_err,       32'(m_rng));
    if (n_reset && bus.mem_wr_en && bus.mem_ready) log_q.push_back({bus.mem_addr, bus.mem_wr_data});
  end

  task automatic step(); @(posedge clk); #2; endtask

  task automatic new_map(input logic [AW-1:0] b);
    start = 0; step(); log_q.delete();
    base_addr = b; start = 1; step();
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.in_valid = 1; bus.in_data = d; step(); bus.in_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    chk("done_within_budget", done, 1);
  endtask

  task automatic stream_rand(input int n, input int lo, input int hi);
    int sent = 0, guard = 0;
    while (sent < n && guard < 400) begin
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      if (!bus.stall && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1; bus.in_data = 16'($urandom_range(lo, hi)); sent++;
      end else bus.in_valid = 0;
      step(); guard++;
    end
    bus.in_valid = 0; bus.mem_ready = 1;
    chk("stream_budget", sent, n);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.mem_ready = 0;
    #1 n_reset = 0;
    step(); step();
    chk("rst_stall", bus.stall, 0);     chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_addr", bus.mem_addr, 0);   chk("rst_data", bus.mem_wr_data, 0);
    chk("rst_done", done, 0);           chk("rst_ovf", overflow, 0);
    chk("rst_rng", range_err, 0);
    n_reset = 1; step();

    // Back-to-back 4x4 map at 0x100.
    new_map(10'h100); bus.mem_ready = 1;
    for (int i = 0; i < 16; i++) send(16'(i));
    chk("t1_not_done_yet", done, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_nwrites", log_q.size(), 16);
    chk("t1_first", log_q[0], {10'h100, 16'd0});
    chk("t1_last", log_q[15], {10'h10F, 16'd15});

    // Memory backpressure: FIFO fills, ninth sample dropped.
    new_map(10'h000); bus.mem_ready = 0;
    for (int i = 0; i < 9; i++) send(16'(100 + i));
    chk("t2_ovf", overflow, 1);
    chk("t2_stall", bus.stall, 1);
    repeat (11) step();
    bus.mem_ready = 1; step();
    for (int i = 9; i < 17; i++) send(16'(100 + i));
    wait_done(50);
    chk("t2_nwrites", log_q.size(), 16);
    chk("t2_after_drop", log_q[8], {10'h008, 16'd109});

    // Address wrap from 0x3FE.
    new_map(10'h3FE);
    stream_rand(16, 0, 6144);
    wait_done(100);
    chk("t3_a0", log_q[0][AW+DW-1:DW], 10'h3FE);
    chk("t3_a2", log_q[2][AW+DW-1:DW], 10'h000);
    chk("t3_a15", log_q[15][AW+DW-1:DW], 10'h00D);
    chk("t3_rng", range_err, 0);

    // Abort mid-map after 5 writes with 3 buffered.
    new_map(10'h050);
    for (int j = 0; j < 8; j++) begin bus.mem_ready = (j <= 5); send(16'(j)); end
    bus.mem_ready = 0;
    chk("t4_written", log_q.size(), 5);
    start = 0; step();
    chk("t4_wr_en", bus.mem_wr_en, 0);
    chk("t4_stall", bus.stall, 0);
    new_map(10'h200);
    stream_rand(16, 0, 6144);
    wait_done(100);
    chk("t4_restart", log_q[0][AW+DW-1:DW], 10'h200);

    // Range boundaries.
    new_map(10'h000); bus.mem_ready = 1;
    send(16'd6144);
    chk("t5_at_max", range_err, 0);
    send(16'hFFFF);
`ifdef FMAP_WB_RANGE_CHECK_EN
    chk("t5_neg", range_err, 1);
`else
    chk("t5_neg", range_err, 0);
`endif
    send(16'd6145);
    stream_rand(13, 0, 6144);
    wait_done(100);
    chk("t5_d1", log_q[1][DW-1:0], 16'hFFFF);
    chk("t5_d2", log_q[2][DW-1:0], 16'd6145);

    // Async reset while draining.
    new_map(10'h120);
    for (int i = 0; i < 16; i++) begin bus.mem_ready = (i < 12); send(16'(i + 40)); end
    #1 n_reset = 0; #1;
    chk("t6_wr_en", bus.mem_wr_en, 0); chk("t6_addr", bus.mem_addr, 0);
    chk("t6_data", bus.mem_wr_data, 0); chk("t6_stall", bus.stall, 0);
    chk("t6_done", done, 0);
    step(); n_reset = 1; step();

    // Random maps.
    for (int k = 0; k < 4; k++) begin
      new_map(AW'($urandom));
      stream_rand(16, 0, 8000);
      wait_done(100);
      chk("rnd_nwrites", log_q.size(), 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
